voice_allocator_p: RTL
======================

Name: voice_allocator_p

Overview:
- Parametrised polyphonic voice allocator and dispatcher.
- Decodes 16-bit note commands into NVOICES voice slots, each holding a MIDI note and velocity.
- Streams one slot per clk_en tick, round-robin, into the phase/sine pipeline.
- Adds velocity, retrigger of held notes, oldest-voice stealing, an active count and overflow reporting.

Parameters:
- NVOICES, 10: number of voice slots, 2..32.
- IDX_W, 5: voice index width; must satisfy 2^IDX_W >= NVOICES.
- AGE_W, 4: per-voice age counter width, saturating.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_en  in  1  dispatch advance strobe (sample-rate tick).
- i_data  in  16  command word: [15] 1=note-on, 0=note-off; [14:8] midi; [7] reserved; [6:0] velocity.
- i_valid  in  1  command strobe; i_data is sampled only when i_valid=1.
- o_midi  out  7  note of the dispatched slot; 0 = silent.
- o_velocity  out  7  velocity of the dispatched slot.
- o_voice  out  IDX_W  index of the dispatched slot.
- o_valid  out  1  dispatched slot is active (o_midi != 0).
- o_active_count  out  IDX_W+1  number of occupied slots.
- o_overflow  out  1  sticky flag: a note-on was dropped or a voice was stolen.

Behaviour:
- Reset (async assert, sync release):
  - All slots midi=0, vel=0, age=0.
  - Dispatch index=0.
  - All outputs 0.
- Command handling, on an i_valid cycle, takes effect at the next edge:
  - Note-on, midi=0: ignored.
  - Note-on, midi already held in slot k: retrigger. vel[k] <= new velocity, age[k] <= 0. No new allocation.
  - Note-on, otherwise: allocate the lowest-index free slot (midi==0). Set midi and velocity, age <= 0.
  - Every accepted note-on increments the age of all other occupied slots, saturating at 2^AGE_W-1.
  - Note-on with no free slot: see Optional Feature.
  - Note-off, midi=0x7F (STOP_ALL): clear every slot and o_overflow.
  - Note-off, other midi: clear the lowest-index slot holding that midi. No match: no-op.
  - Note-off for midi 0: no-op.
- Dispatch, on a clk_en cycle:
  - Register o_midi, o_velocity, o_voice and o_valid from slot[idx], using the pre-update slot contents.
  - idx <= idx+1, wrapping NVOICES-1 -> 0.
  - Latency: a command is visible the next time its slot is dispatched, 1..NVOICES ticks later.
  - Without clk_en, all dispatch outputs hold.
- Same-cycle command and dispatch of the same slot: dispatch shows the old value; the slot updates.
- o_active_count: registered popcount of occupied slots, one cycle after the slot update.
- reset_n asserted mid-stream: immediate clear. The first post-reset dispatch is slot 0.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: a note-on with all slots full steals the slot with the largest age (ties: lowest index). It overwrites midi and velocity, resets age, and sets o_overflow.
- Undefined: the note-on is dropped, slots are unchanged and o_overflow is set.
- Age counters are always present, so behaviour is otherwise identical.

Decomposition:
- Shared header synth_defs.vh holds:
  - command bit positions (CMD_BIT=15, MIDI_MSB/LSB=14/8, VEL_MSB/LSB=6/0);
  - MIDI_STOP_ALL=7'h7F and MIDI_SILENT=7'h00.
- One sub-module, voice_select. It is combinational and takes the slot midi and age vectors plus the request midi. It returns:
  - match flag and match index;
  - free flag and lowest free index;
  - oldest index.
- voice_allocator_p owns all registers, the dispatch counter and the output stage.

Test Plan:
- Reset, then 10 clk_en ticks: o_voice cycles 0..9, o_valid=0, o_active_count=0, o_overflow=0.
- Note-on 0x3C vel 0x40: o_active_count=1. Slot 0 dispatches midi 0x3C, vel 0x40, o_valid=1; slots 1..9 are o_valid=0.
- Note-on 0x3C vel 0x7F again: o_active_count stays 1 and slot 0 vel becomes 0x7F.
- Note-off 0x3C: slot 0 o_valid=0. Note-off 0x50 (not held): no change.
- 11 note-ons 0x30..0x3A:
  - With VOICE_STEAL_EN: 0x3A replaces 0x30 in slot 0 and o_overflow=1.
  - Without: slot 0 stays 0x30 and o_overflow=1.
  - In both cases o_active_count=10.
- Fill 4 slots, then send note-off 0x7F: all slots are cleared, o_active_count=0 and o_overflow=0.
- Assert reset_n low mid-dispatch: outputs clear immediately and the next dispatch is o_voice=0.

Source files
------------

// File: rtl/voice_allocator_p_pkg.sv
// Shared command-word layout and MIDI constants for the voice allocator.
package voice_allocator_p_pkg;

  localparam int MIDI_W   = 7;
  localparam int VEL_W    = 7;
  localparam int CMD_BIT  = 15;
  localparam int MIDI_MSB = 14;
  localparam int MIDI_LSB = 8;
  localparam int VEL_MSB  = 6;
  localparam int VEL_LSB  = 0;

  localparam logic [MIDI_W-1:0] MIDI_STOP_ALL = 7'h7F;
  localparam logic [MIDI_W-1:0] MIDI_SILENT   = 7'h00;

  typedef struct packed {
    logic              note_on;
    logic [MIDI_W-1:0] midi;
    logic [VEL_W-1:0]  vel;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [15:0] data);
    cmd_t c;
    c.note_on = data[CMD_BIT];
    c.midi    = data[MIDI_MSB:MIDI_LSB];
    c.vel     = data[VEL_MSB:VEL_LSB];
    return c;
  endfunction

endpackage

// File: rtl/voice_allocator_p_voice_select.sv
// Combinational slot search: held-note match, lowest free slot and oldest slot.
module voice_select
  import voice_allocator_p_pkg::*;
#(
  parameter int NVOICES = 10,
  parameter int IDX_W   = 5,
  parameter int AGE_W   = 4
) (
  input  logic [NVOICES-1:0][MIDI_W-1:0] slot_midi,
  input  logic [NVOICES-1:0][AGE_W-1:0]  slot_age,
  input  logic [MIDI_W-1:0]              req_midi,
  output logic                           match,
  output logic [IDX_W-1:0]               match_idx,
  output logic                           free,
  output logic [IDX_W-1:0]               free_idx,
  output logic [IDX_W-1:0]               oldest_idx
);

  logic [AGE_W-1:0] oldest_age;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    free      = 1'b0;
    free_idx  = '0;
    for (int k = NVOICES - 1; k >= 0; k--) begin
      if (req_midi != MIDI_SILENT && slot_midi[k] == req_midi) begin
        match     = 1'b1;
        match_idx = IDX_W'(k);
      end
      if (slot_midi[k] == MIDI_SILENT) begin
        free     = 1'b1;
        free_idx = IDX_W'(k);
      end
    end
  end

  // Strict compare keeps the lowest index on age ties.
  always_comb begin
    oldest_idx = '0;
    oldest_age = slot_age[0];
    for (int k = 1; k < NVOICES; k++) begin
      if (slot_age[k] > oldest_age) begin
        oldest_age = slot_age[k];
        oldest_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/voice_allocator_p.sv
// Polyphonic voice allocator with round-robin dispatch.
// Optional macro VOICE_STEAL_EN: steal the oldest voice when all slots are full.
module voice_allocator_p
  import voice_allocator_p_pkg::*;
#(
  parameter int NVOICES = 10,
  parameter int IDX_W   = 5,
  parameter int AGE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic [15:0]       i_data,
  input  logic              i_valid,
  output logic [MIDI_W-1:0] o_midi,
  output logic [VEL_W-1:0]  o_velocity,
  output logic [IDX_W-1:0]  o_voice,
  output logic              o_valid,
  output logic [IDX_W:0]    o_active_count,
  output logic              o_overflow
);

`ifdef VOICE_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  logic [NVOICES-1:0][MIDI_W-1:0] midi_q, midi_d;
  logic [NVOICES-1:0][VEL_W-1:0]  vel_q, vel_d;
  logic [NVOICES-1:0][AGE_W-1:0]  age_q, age_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [MIDI_W-1:0]              o_midi_q, o_midi_d;
  logic [VEL_W-1:0]               o_velocity_q, o_velocity_d;
  logic [IDX_W-1:0]               o_voice_q, o_voice_d;
  logic                           o_valid_q, o_valid_d;
  logic [IDX_W:0]                 active_count_q, active_count_d;
  logic                           overflow_q, overflow_d;

  cmd_t             cmd;
  logic             sel_match, sel_free;
  logic [IDX_W-1:0] sel_match_idx, sel_free_idx, sel_oldest_idx;
  logic [IDX_W-1:0] target;
  logic             accept;
  logic             unused_reserved;

  assign cmd             = decode_cmd(i_data);
  assign unused_reserved = i_data[7];

  voice_select #(
    .NVOICES(NVOICES),
    .IDX_W  (IDX_W),
    .AGE_W  (AGE_W)
  ) u_voice_select (
    .slot_midi (midi_q),
    .slot_age  (age_q),
    .req_midi  (cmd.midi),
    .match     (sel_match),
    .match_idx (sel_match_idx),
    .free      (sel_free),
    .free_idx  (sel_free_idx),
    .oldest_idx(sel_oldest_idx)
  );

  always_comb begin
    target = sel_match ? sel_match_idx : (sel_free ? sel_free_idx : sel_oldest_idx);
    accept = sel_match || sel_free || STEAL_EN;
  end

  always_comb begin
    midi_d     = midi_q;
    vel_d      = vel_q;
    age_d      = age_q;
    overflow_d = overflow_q;

    if (i_valid && cmd.note_on && cmd.midi != MIDI_SILENT) begin
      if (!sel_match && !sel_free) overflow_d = 1'b1;
      if (accept) begin
        for (int k = 0; k < NVOICES; k++) begin
          if (target == IDX_W'(k)) begin
            midi_d[k] = cmd.midi;
            vel_d[k]  = cmd.vel;
            age_d[k]  = '0;
          end else if (midi_q[k] != MIDI_SILENT && age_q[k] != AGE_MAX) begin
            age_d[k] = age_q[k] + 1'b1;
          end
        end
      end
    end else if (i_valid && !cmd.note_on) begin
      if (cmd.midi == MIDI_STOP_ALL) begin
        midi_d     = '0;
        vel_d      = '0;
        age_d      = '0;
        overflow_d = 1'b0;
      end else if (sel_match) begin
        for (int k = 0; k < NVOICES; k++) begin
          if (sel_match_idx == IDX_W'(k)) begin
            midi_d[k] = MIDI_SILENT;
            vel_d[k]  = '0;
            age_d[k]  = '0;
          end
        end
      end
    end
  end

  // Dispatch reads the pre-update slot contents, so a same-edge command shows next lap.
  always_comb begin
    idx_d        = idx_q;
    o_midi_d     = o_midi_q;
    o_velocity_d = o_velocity_q;
    o_voice_d    = o_voice_q;
    o_valid_d    = o_valid_q;
    if (clk_en) begin
      idx_d     = (idx_q == IDX_W'(NVOICES - 1)) ? '0 : idx_q + 1'b1;
      o_voice_d = idx_q;
      for (int k = 0; k < NVOICES; k++) begin
        if (idx_q == IDX_W'(k)) begin
          o_midi_d     = midi_q[k];
          o_velocity_d = vel_q[k];
          o_valid_d    = (midi_q[k] != MIDI_SILENT);
        end
      end
    end
  end

  always_comb begin
    active_count_d = '0;
    for (int k = 0; k < NVOICES; k++) begin
      active_count_d = active_count_d + (IDX_W + 1)'(midi_q[k] != MIDI_SILENT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      midi_q         <= '0;
      vel_q          <= '0;
      age_q          <= '0;
      idx_q          <= '0;
      o_midi_q       <= '0;
      o_velocity_q   <= '0;
      o_voice_q      <= '0;
      o_valid_q      <= 1'b0;
      active_count_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      midi_q         <= midi_d;
      vel_q          <= vel_d;
      age_q          <= age_d;
      idx_q          <= idx_d;
      o_midi_q       <= o_midi_d;
      o_velocity_q   <= o_velocity_d;
      o_voice_q      <= o_voice_d;
      o_valid_q      <= o_valid_d;
      active_count_q <= active_count_d;
      overflow_q     <= overflow_d;
    end
  end

  assign o_midi         = o_midi_q;
  assign o_velocity     = o_velocity_q;
  assign o_voice        = o_voice_q;
  assign o_valid        = o_valid_q;
  assign o_active_count = active_count_q;
  assign o_overflow     = overflow_q;

endmodule
